// File: rtl/arp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : arp_tx_sched
// Purpose : Round-robin ARP reply/query scheduler; emits 60-byte arphdr frames
//           as 8 beats on a 64-bit AXI-Stream. Optional ARP_GRATUITOUS_EN adds
//           a periodic gratuitous-ARP request source.
// Rev     : 1.0
// ============================================================================
module arp_tx_sched #(
  parameter logic [31:0] GARP_INTERVAL = 32'd156_250_000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk156,
  input  logic             rst156_n,
  input  logic [47:0]      local_mac,
  input  logic [31:0]      local_ip,
  input  logic             rep_req_valid,
  output logic             rep_req_ready,
  input  logic [47:0]      rep_req_mac,
  input  logic [31:0]      rep_req_ip,
  input  logic             qry_req_valid,
  output logic             qry_req_ready,
  input  logic [31:0]      qry_req_ip,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] reply_cnt,
  output logic [CNT_W-1:0] query_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH_P_ARP = 16'h0806;

  state_t       state;
  logic [2:0]   beat;
  logic         last_rep;   // 1 when the reply side won the most recent rep/qry grant
  logic         cur_rep;
  logic [335:0] hdr;        // 42 header bytes, wire byte 0 in the MSBs
  logic [335:0] hdr_new;
  logic         garp_pending;
  logic         grant_rep, grant_qry, grant_garp, grant_any;
  logic         fire;

  // Gather beat b of the frame: byte j of the beat lands on tdata[8j+7:8j].
  function automatic logic [63:0] beat_data(input logic [335:0] h, input logic [2:0] b);
    logic [511:0] f;
    logic [63:0]  d;
    f = {h, 176'd0};
    d = '0;
    for (int j = 0; j < 8; j++)
      d[8*j +: 8] = f[511 - 8*(8*int'(b) + j) -: 8];
    return d;
  endfunction

  always_comb begin
    grant_rep  = 1'b0;
    grant_qry  = 1'b0;
    grant_garp = 1'b0;
    if (state == IDLE) begin
      if (rep_req_valid && (!qry_req_valid || !last_rep))
        grant_rep = 1'b1;
      else if (qry_req_valid)
        grant_qry = 1'b1;
      else if (garp_pending)
        grant_garp = 1'b1;
    end
  end

  assign grant_any     = grant_rep | grant_qry | grant_garp;
  assign rep_req_ready = grant_rep;
  assign qry_req_ready = grant_qry;
  assign busy          = (state == SEND);
  assign fire          = m_axis_tvalid && m_axis_tready;

  always_comb begin
    hdr_new = {BCAST_MAC, local_mac, ETH_P_ARP, 16'h0001, 16'h0800, 8'd6, 8'd4,
               16'd1, local_mac, local_ip, 48'd0, qry_req_ip};
    if (grant_rep)
      hdr_new = {rep_req_mac, local_mac, ETH_P_ARP, 16'h0001, 16'h0800, 8'd6, 8'd4,
                 16'd2, local_mac, local_ip, rep_req_mac, rep_req_ip};
    else if (grant_garp)
      hdr_new = {BCAST_MAC, local_mac, ETH_P_ARP, 16'h0001, 16'h0800, 8'd6, 8'd4,
                 16'd1, local_mac, local_ip, 48'd0, local_ip};
  end

  always_ff @(posedge clk156 or negedge rst156_n) begin
    if (!rst156_n) begin
      state         <= IDLE;
      beat          <= 3'd0;
      last_rep      <= 1'b0;
      cur_rep       <= 1'b0;
      hdr           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 64'd0;
      m_axis_tkeep  <= 8'd0;
      m_axis_tlast  <= 1'b0;
      reply_cnt     <= '0;
      query_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state         <= SEND;
            beat          <= 3'd0;
            hdr           <= hdr_new;
            cur_rep       <= grant_rep;
            // Gratuitous grants leave the rep/qry fairness pointer untouched.
            if (grant_rep || grant_qry)
              last_rep <= grant_rep;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_data(hdr_new, 3'd0);
            m_axis_tkeep  <= 8'hFF;
            m_axis_tlast  <= 1'b0;
          end
        end
        SEND: begin
          if (fire) begin
            if (m_axis_tlast) begin
              state         <= IDLE;
              beat          <= 3'd0;
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= 64'd0;
              m_axis_tkeep  <= 8'd0;
              m_axis_tlast  <= 1'b0;
              if (cur_rep)
                reply_cnt <= reply_cnt + 1'b1;
              else
                query_cnt <= query_cnt + 1'b1;
            end else begin
              beat          <= beat + 3'd1;
              m_axis_tdata  <= beat_data(hdr, beat + 3'd1);
              m_axis_tkeep  <= (beat == 3'd6) ? 8'h0F : 8'hFF;
              m_axis_tlast  <= (beat == 3'd6);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARP_GRATUITOUS_EN
  logic [31:0] garp_timer;
  logic        garp_first;
  logic        garp_pend_q;

  always_ff @(posedge clk156 or negedge rst156_n) begin
    if (!rst156_n) begin
      garp_timer  <= GARP_INTERVAL - 32'd1;
      garp_first  <= 1'b1;
      garp_pend_q <= 1'b0;
    end else begin
      garp_first <= 1'b0;
      if (garp_timer == 32'd0)
        garp_timer <= GARP_INTERVAL - 32'd1;
      else
        garp_timer <= garp_timer - 32'd1;
      // A fresh expiry wins over a same-cycle grant so no interval is lost.
      if (garp_first || (garp_timer == 32'd0))
        garp_pend_q <= 1'b1;
      else if (grant_garp)
        garp_pend_q <= 1'b0;
    end
  end

  assign garp_pending = garp_pend_q;
`else
  logic unused_garp;
  assign unused_garp  = ^GARP_INTERVAL;
  assign garp_pending = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arp_tx_sched.sv
`default_nettype none
// Directed bench for arp_tx_sched (CNT_W=4): frame content, arbitration order,
// backpressure stability, mid-frame reset and counter wrap.
module tb_arp_tx_sched;

  logic        clk156 = 1'b0;
  logic        rst156_n;
  logic [47:0] local_mac;
  logic [31:0] local_ip;
  logic        rep_req_valid, rep_req_ready;
  logic [47:0] rep_req_mac;
  logic [31:0] rep_req_ip;
  logic        qry_req_valid, qry_req_ready;
  logic [31:0] qry_req_ip;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        busy;
  logic [3:0]  reply_cnt, query_cnt;

  arp_tx_sched #(.GARP_INTERVAL(32'd100), .CNT_W(4)) dut (
    .clk156(clk156), .rst156_n(rst156_n),
    .local_mac(local_mac), .local_ip(local_ip),
    .rep_req_valid(rep_req_valid), .rep_req_ready(rep_req_ready),
    .rep_req_mac(rep_req_mac), .rep_req_ip(rep_req_ip),
    .qry_req_valid(qry_req_valid), .qry_req_ready(qry_req_ready),
    .qry_req_ip(qry_req_ip),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .busy(busy),
    .reply_cnt(reply_cnt), .query_cnt(query_cnt)
  );

  always #5 clk156 = ~clk156;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rep_rdy_cnt = 0;
  int qry_rdy_cnt = 0;
  int grant_cyc = 0;
  int first_cyc = 0;
  logic [63:0] got_d[$];
  logic [7:0]  got_k[$];
  logic        got_l[$];
  bit          order[$];

  typedef struct {
    bit          rep;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [3:0]  exp_rep_cnt;
    logic [3:0]  exp_qry_cnt;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference frame built byte by byte in wire order.
  function automatic logic [63:0] exp_beat(input bit rep, input logic [47:0] pm,
                                           input logic [31:0] pi, input int k);
    logic [7:0]  b[64];
    logic [63:0] d;
    foreach (b[i]) b[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      b[i]    = rep ? pm[47-8*i -: 8] : 8'hFF;
      b[6+i]  = local_mac[47-8*i -: 8];
      b[22+i] = local_mac[47-8*i -: 8];
      b[32+i] = rep ? pm[47-8*i -: 8] : 8'h00;
    end
    b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
    b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
    b[20] = 8'h00; b[21] = rep ? 8'h02 : 8'h01;
    for (int i = 0; i < 4; i++) begin
      b[28+i] = local_ip[31-8*i -: 8];
      b[38+i] = pi[31-8*i -: 8];
    end
    d = '0;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = b[8*k+j];
    return d;
  endfunction

  initial forever @(posedge clk156) cyc++;

  // Monitor: grants, accepted beats, stall stability.
  initial begin
    bit          stalled = 1'b0;
    bit          prev_valid = 1'b0;
    logic [63:0] held_d = '0;
    logic [7:0]  held_k = '0;
    logic        held_l = 1'b0;
    forever begin
      @(negedge clk156);
      if (rep_req_valid && rep_req_ready) begin
        rep_rdy_cnt++; order.push_back(1'b1); grant_cyc = cyc;
      end
      if (qry_req_valid && qry_req_ready) begin
        qry_rdy_cnt++; order.push_back(1'b0); grant_cyc = cyc;
      end
      if (m_axis_tvalid && !prev_valid) first_cyc = cyc;
      if (stalled && rst156_n) begin
        check("stall_valid", m_axis_tvalid, 1'b1);
        check("stall_data", m_axis_tdata, held_d);
        check("stall_keeplast", {m_axis_tkeep, m_axis_tlast}, {held_k, held_l});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_k.push_back(m_axis_tkeep);
        got_l.push_back(m_axis_tlast);
      end
      stalled    = m_axis_tvalid && !m_axis_tready && rst156_n;
      held_d     = m_axis_tdata;
      held_k     = m_axis_tkeep;
      held_l     = m_axis_tlast;
      prev_valid = m_axis_tvalid;
    end
  end

  task automatic clear_capture();
    got_d.delete(); got_k.delete(); got_l.delete(); order.delete();
  endtask

  task automatic tick();
    @(posedge clk156); #1;
  endtask

  task automatic send_one(input bit rep, input logic [47:0] mac, input logic [31:0] ip,
                          input bit bp);
    int r0, q0, n, idx;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    r0 = rep_rdy_cnt;
    q0 = qry_rdy_cnt;
    clear_capture();
    if (rep) begin
      rep_req_valid = 1'b1; rep_req_mac = mac; rep_req_ip = ip;
    end else begin
      qry_req_valid = 1'b1; qry_req_ip = ip;
    end
    n = 0;
    while (rep_rdy_cnt == r0 && qry_rdy_cnt == q0 && n < 20) begin tick(); n++; end
    rep_req_valid = 1'b0;
    qry_req_valid = 1'b0;
    check("rep_ready_pulses", rep_rdy_cnt - r0, rep ? 1 : 0);
    check("qry_ready_pulses", qry_rdy_cnt - q0, rep ? 0 : 1);
    n = 0; idx = 0;
    while (got_d.size() < 8 && n < 60) begin
      if (bp) begin m_axis_tready = pat[idx % 4]; idx++; end
      tick(); n++;
    end
    m_axis_tready = 1'b1;
    check("first_beat_latency", first_cyc - grant_cyc, 1);
    check("beat_count", got_d.size(), 8);
    check("busy_after_frame", busy, 1'b0);
  endtask

  task automatic check_frame(input int base, input bit rep, input logic [47:0] mac,
                             input logic [31:0] ip);
    for (int k = 0; k < 8; k++) begin
      if (base + k < got_d.size()) begin
        check($sformatf("beat%0d_data", base + k), got_d[base+k], exp_beat(rep, mac, ip, k));
        check($sformatf("beat%0d_keep", base + k), got_k[base+k], (k == 7) ? 8'h0F : 8'hFF);
        check($sformatf("beat%0d_last", base + k), got_l[base+k], (k == 7));
      end else begin
        check($sformatf("beat%0d_missing", base + k), 0, 1);
      end
    end
  endtask

  initial begin
    int n, r0, q0;
    logic [3:0] ord;
    local_mac     = 48'h0200_0000_0001;
    local_ip      = 32'hC0A8_0A01;
    rst156_n      = 1'b0;
    rep_req_valid = 1'b0; rep_req_mac = '0; rep_req_ip = '0;
    qry_req_valid = 1'b0; qry_req_ip = '0;
    m_axis_tready = 1'b1;

    vecs[0] = '{1'b1, 48'h0200_0000_0002, 32'hC0A8_0A03, 4'd1, 4'd0};
    vecs[1] = '{1'b0, 48'h0,              32'hC0A8_0A07, 4'd1, 4'd1};
    vecs[2] = '{1'b1, 48'h0A1B_2C3D_4E5F, 32'h0A00_0001, 4'd2, 4'd1};
    vecs[3] = '{1'b0, 48'h0,              32'hFFFF_FFFF, 4'd2, 4'd2};

    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, 9'd0);
    check("rst_busy_ready", {busy, rep_req_ready, qry_req_ready}, 3'd0);
    check("rst_counters", {reply_cnt, query_cnt}, 8'd0);
    rst156_n = 1'b1;
    repeat (3) tick();
    check("idle_no_frame", got_d.size(), 0);

    // Single requests from the vector table.
    foreach (vecs[v]) begin
      send_one(vecs[v].rep, vecs[v].mac, vecs[v].ip, 1'b0);
      check_frame(0, vecs[v].rep, vecs[v].mac, vecs[v].ip);
      check($sformatf("vec%0d_reply_cnt", v), reply_cnt, vecs[v].exp_rep_cnt);
      check($sformatf("vec%0d_query_cnt", v), query_cnt, vecs[v].exp_qry_cnt);
      if (v == 0 && got_d.size() == 8) begin
        check("v0_beat0_hand", got_d[0], 64'h0002_0200_0000_0002);
        check("v0_beat1_ethertype", got_d[1], 64'h0100_0608_0100_0000);
        check("v0_beat2_op", got_d[2], 64'h0002_0200_0406_0008);
        check("v0_beat5_tip", got_d[5], 64'h0000_0000_0000_030A);
        check("v0_beat7_zero", got_d[7], 64'd0);
      end
      tick();
    end

    // Both requesters contend; reply re-requests right after its grant.
    clear_capture();
    r0 = rep_rdy_cnt; q0 = qry_rdy_cnt;
    rep_req_mac = 48'h0200_0000_0002; rep_req_ip = 32'hC0A8_0A03;
    qry_req_ip  = 32'hC0A8_0A07;
    rep_req_valid = 1'b1; qry_req_valid = 1'b1;
    n = 0;
    while (got_d.size() < 32 && n < 200) begin
      tick(); n++;
      rep_req_valid = (rep_rdy_cnt - r0) < 2;
      qry_req_valid = (qry_rdy_cnt - q0) < 2;
    end
    rep_req_valid = 1'b0; qry_req_valid = 1'b0;
    check("arb_grants", order.size(), 4);
    ord = '0;
    if (order.size() == 4) ord = {order[0], order[1], order[2], order[3]};
    check("arb_order_RQRQ", ord, 4'b1010);
    check("arb_beats", got_d.size(), 32);
    for (int f = 0; f < 4; f++)
      check_frame(8*f, (f % 2) == 0, rep_req_mac, (f % 2) == 0 ? rep_req_ip : qry_req_ip);
    if (got_d.size() == 32) begin
      check("qry_dest_bcast", got_d[8], 64'h0002_FFFF_FFFF_FFFF);
      check("qry_target_mac0", got_d[12], 64'hA8C0_0000_0000_0000);
    end
    check("arb_counters", {reply_cnt, query_cnt}, {4'd4, 4'd4});
    tick();

    // Backpressure 1,0,0,1 during a reply frame.
    send_one(1'b1, 48'h0200_0000_0002, 32'hC0A8_0A03, 1'b1);
    check_frame(0, 1'b1, 48'h0200_0000_0002, 32'hC0A8_0A03);
    repeat (3) tick();
    check("bp_no_dup", got_d.size(), 8);
    check("bp_reply_cnt", reply_cnt, 4'd5);

    // Reset while beat 4 is presented.
    clear_capture();
    rep_req_valid = 1'b1;
    n = 0;
    while (got_d.size() < 4 && n < 30) begin
      tick(); n++;
      if (rep_rdy_cnt > 0 && order.size() > 0) rep_req_valid = 1'b0;
    end
    rep_req_valid = 1'b0;
    check("pre_reset_beat4_valid", m_axis_tvalid, 1'b1);
    rst156_n = 1'b0;
    #1;
    check("reset_async_tvalid", m_axis_tvalid, 1'b0);
    check("reset_counters", {reply_cnt, query_cnt}, 8'd0);
    check("reset_busy", busy, 1'b0);
    repeat (2) tick();
    rst156_n = 1'b1;
    repeat (5) tick();
    check("no_resume", got_d.size(), 4);
    send_one(1'b1, 48'h0200_0000_0002, 32'hC0A8_0A03, 1'b0);
    check_frame(0, 1'b1, 48'h0200_0000_0002, 32'hC0A8_0A03);
    check("post_reset_reply_cnt", reply_cnt, 4'd1);
    tick();

    // Counter wrap: 17 replies since reset.
    for (int i = 0; i < 15; i++) begin
      send_one(1'b1, 48'h0200_0000_0009, 32'hC0A8_0A09, 1'b0);
      tick();
    end
    check("wrap_16_to_0", reply_cnt, 4'd0);
    send_one(1'b1, 48'h0200_0000_0009, 32'hC0A8_0A09, 1'b0);
    check("wrap_17_reads_1", reply_cnt, 4'd1);
    check("wrap_query_cnt", query_cnt, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
